// File: rtl/pll_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reconfig_sequencer
//
// Drives the reconfiguration management port of a reconfigurable PLL from a
// mode request issued by the video-timing mode selector.
//
// A rising edge on the asynchronous mode_change level is synchronised and
// detected. The sequencer then captures the mode tag and the M, N and C
// counter words, and issues the complete register write sequence:
//     mode(0) <- 1
//     M(4)    <- {14'h0, M}
//     N(3)    <- {14'h0, N}
//     C(5)    <- {9'h0, i[4:0], C[i]}     for i = 0 .. NUM_C-1
//     BW(8)   <- BW_SETTING
//     CP(9)   <- CP_SETTING
//     start(2)<- 1
// Finally it polls the status register (address 1) until bit 0 reads 1, or
// until TIMEOUT poll cycles have passed.
//
// Every write honours mgmt_waitrequest and is followed by WRITE_GAP idle
// cycles. Requests arriving while a sequence runs are collapsed into a single
// pending request, which starts one cycle after the sequencer returns to idle.
//
// Parameters
//   NUM_C      number of C counters written (1..4)
//   WRITE_GAP  idle cycles with mgmt_write low after each accepted write (0..7)
//   TIMEOUT    poll cycles before giving up (>= 2)
//   BW_SETTING bandwidth register data
//   CP_SETTING charge-pump register data
//
// Ports
//   clk              clock
//   reset_n          asynchronous active-low reset
//   mode             mode tag, captured at sequence start
//   mode_change      asynchronous request level; rising edge requests
//   m_value          M counter word
//   n_value          N counter word
//   c_values         C counter words, C[i] = bits [18i+17:18i]
//   mgmt_readdata    management read data (only bit 0 is used)
//   mgmt_waitrequest management slave stall
//   mgmt_read        read strobe
//   mgmt_write       write strobe
//   mgmt_address     register address
//   mgmt_writedata   write data
//   busy             a sequence is in progress
//   done             one-cycle pulse on successful completion
//   error            sticky timeout flag, cleared when a sequence starts
//   active_mode      mode tag of the last successful sequence
// -----------------------------------------------------------------------------
module pll_reconfig_sequencer #(
    parameter int          NUM_C      = 1,
    parameter int          WRITE_GAP  = 2,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] BW_SETTING = 32'h6,
    parameter logic [31:0] CP_SETTING = 32'h3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            mode,
    input  logic                  mode_change,
    input  logic [17:0]           m_value,
    input  logic [17:0]           n_value,
    input  logic [18*NUM_C-1:0]   c_values,
    input  logic [31:0]           mgmt_readdata,
    input  logic                  mgmt_waitrequest,
    output logic                  mgmt_read,
    output logic                  mgmt_write,
    output logic [5:0]            mgmt_address,
    output logic [31:0]           mgmt_writedata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            active_mode
);

    // -------------------------------------------------------------------------
    // Step numbering of the write sequence
    // -------------------------------------------------------------------------
    localparam int          NUM_STEPS  = 6 + NUM_C;
    localparam logic [3:0]  STEP_M     = 4'd1;
    localparam logic [3:0]  STEP_N     = 4'd2;
    localparam logic [3:0]  STEP_BW    = 4'(3 + NUM_C);
    localparam logic [3:0]  STEP_CP    = 4'(4 + NUM_C);
    localparam logic [3:0]  STEP_LAST  = 4'(NUM_STEPS - 1);

    // Register map of the PLL reconfiguration block
    localparam logic [5:0]  ADDR_MODE   = 6'd0;
    localparam logic [5:0]  ADDR_STATUS = 6'd1;
    localparam logic [5:0]  ADDR_START  = 6'd2;
    localparam logic [5:0]  ADDR_N      = 6'd3;
    localparam logic [5:0]  ADDR_M      = 6'd4;
    localparam logic [5:0]  ADDR_C      = 6'd5;
    localparam logic [5:0]  ADDR_BW     = 6'd8;
    localparam logic [5:0]  ADDR_CP     = 6'd9;

    // Timeout counter must be able to hold the value TIMEOUT itself
    localparam int              TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_CNT = TW'(TIMEOUT);
    localparam logic [2:0]      GAP_LOAD    = 3'(WRITE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_POLL
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_reg;
    logic [2:0]             sync_reg;
    logic                   pending_reg;
    logic [3:0]             step_reg;
    logic [2:0]             gap_reg;
    logic [TW-1:0]          tcnt_reg;
    logic [3:0]             mode_reg;
    logic [17:0]            m_reg;
    logic [17:0]            n_reg;
    logic [18*NUM_C-1:0]    c_reg;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                   request;
    logic [3:0]             step_next;
    logic [5:0]             addr_next;
    logic [31:0]            data_next;
    logic [TW-1:0]          tcnt_next;
    logic [17:0]            c_word [NUM_C];

    // Only the done bit of the status word matters; the rest is folded away.
    logic                   unused_readdata;
    assign unused_readdata = ^mgmt_readdata[31:1];

    // Rising edge seen between the second and third synchroniser flops, so the
    // first flop acts purely as a metastability filter.
    assign request   = sync_reg[1] & ~sync_reg[2];
    assign step_next = step_reg + 4'd1;
    assign tcnt_next = tcnt_reg + {{(TW-1){1'b0}}, 1'b1};

    // Split the captured C words into individually addressable words
    generate
        for (genvar gi = 0; gi < NUM_C; gi++) begin : g_c_word
            assign c_word[gi] = c_reg[18*gi +: 18];
        end
    endgenerate

    // Address/data of the step that follows the current one. Step 0 is never
    // looked up here: it is constant and loaded directly at sequence start.
    always_comb begin
        addr_next = ADDR_START;
        data_next = 32'd1;
        if (step_next == STEP_M) begin
            addr_next = ADDR_M;
            data_next = {14'h0, m_reg};
        end else if (step_next == STEP_N) begin
            addr_next = ADDR_N;
            data_next = {14'h0, n_reg};
        end else if (step_next == STEP_BW) begin
            addr_next = ADDR_BW;
            data_next = BW_SETTING;
        end else if (step_next == STEP_CP) begin
            addr_next = ADDR_CP;
            data_next = CP_SETTING;
        end
        // C counter steps occupy 3 .. 3+NUM_C-1; counter select in bits 22:18
        for (int k = 0; k < NUM_C; k++) begin
            if (step_next == 4'(3 + k)) begin
                addr_next = ADDR_C;
                data_next = {9'h0, 5'(k), c_word[k]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered bus and status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            sync_reg       <= 3'b000;
            pending_reg    <= 1'b0;
            step_reg       <= 4'd0;
            gap_reg        <= 3'd0;
            tcnt_reg       <= '0;
            mode_reg       <= 4'd0;
            m_reg          <= 18'd0;
            n_reg          <= 18'd0;
            c_reg          <= '0;
            mgmt_read      <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            active_mode    <= 4'd0;
        end else begin
            sync_reg <= {sync_reg[1:0], mode_change};
            done     <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    // A fresh edge and a queued request are the same thing here
                    if (request || pending_reg) begin
                        pending_reg    <= 1'b0;
                        mode_reg       <= mode;
                        m_reg          <= m_value;
                        n_reg          <= n_value;
                        c_reg          <= c_values;
                        error          <= 1'b0;
                        busy           <= 1'b1;
                        step_reg       <= 4'd0;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= 32'd1;
                        state_reg      <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (request) begin
                        pending_reg <= 1'b1;
                    end
                    if (!mgmt_waitrequest) begin
                        if (step_reg == STEP_LAST) begin
                            mgmt_write   <= 1'b0;
                            mgmt_read    <= 1'b1;
                            mgmt_address <= ADDR_STATUS;
                            tcnt_reg     <= '0;
                            state_reg    <= S_POLL;
                        end else if (WRITE_GAP == 0) begin
                            // Back-to-back writes: strobe stays high
                            step_reg       <= step_next;
                            mgmt_address   <= addr_next;
                            mgmt_writedata <= data_next;
                        end else begin
                            mgmt_write <= 1'b0;
                            gap_reg    <= GAP_LOAD;
                            state_reg  <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (request) begin
                        pending_reg <= 1'b1;
                    end
                    if (gap_reg == 3'd0) begin
                        step_reg       <= step_next;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= addr_next;
                        mgmt_writedata <= data_next;
                        state_reg      <= S_WRITE;
                    end else begin
                        gap_reg <= gap_reg - 3'd1;
                    end
                end

                S_POLL: begin
                    // A request on the finishing edge is still queued
                    if (request) begin
                        pending_reg <= 1'b1;
                    end
                    tcnt_reg <= tcnt_next;
                    if (!mgmt_waitrequest && mgmt_readdata[0]) begin
                        mgmt_read   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        active_mode <= mode_reg;
                        state_reg   <= S_IDLE;
                    end else if (tcnt_next == TIMEOUT_CNT) begin
                        mgmt_read <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig_sequencer
//
// Scoreboard bench. Stimulus pushes the expected bus transactions and status
// events of each sequence into a queue; a monitor running on the falling edge
// pops and compares whenever the DUT presents an accepted write, the start of
// a status poll, a done pulse or a rising error flag.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_sequencer;

    localparam int NUM_C     = 2;
    localparam int WRITE_GAP = 2;
    localparam int TIMEOUT   = 16;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [3:0]           mode = 4'h0;
    logic                 mode_change = 1'b0;
    logic [17:0]          m_value = 18'h0;
    logic [17:0]          n_value = 18'h0;
    logic [18*NUM_C-1:0]  c_values = '0;
    logic [31:0]          mgmt_readdata = 32'h0;
    logic                 mgmt_waitrequest = 1'b0;
    logic                 mgmt_read;
    logic                 mgmt_write;
    logic [5:0]           mgmt_address;
    logic [31:0]          mgmt_writedata;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [3:0]           active_mode;

    pll_reconfig_sequencer #(
        .NUM_C      (NUM_C),
        .WRITE_GAP  (WRITE_GAP),
        .TIMEOUT    (TIMEOUT),
        .BW_SETTING (32'h6),
        .CP_SETTING (32'h3)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mode             (mode),
        .mode_change      (mode_change),
        .m_value          (m_value),
        .n_value          (n_value),
        .c_values         (c_values),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_read        (mgmt_read),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .active_mode      (active_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [31:0] data;
        int          hold;   // cycles mgmt_write must be high for this write
        int          space;  // cycles since previous accept, 0 = unchecked
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ready_at = 4;      // poll cycle on which status bit 0 becomes 1
    logic [3:0] exp_active = 4'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d, input int hold, input int space);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d; e.hold = hold; e.space = space;
        q.push_back(e);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.addr = (kind == K_RD) ? 6'd1 : 6'd0; e.data = d; e.hold = 0; e.space = 0;
        q.push_back(e);
    endtask

    // Expected transactions of one sequence with NUM_C=2
    task automatic push_seq(input logic [3:0] md, input logic [17:0] m, input logic [17:0] n,
                            input logic [17:0] c0, input logic [17:0] c1,
                            input bit stall_m, input bit timeout);
        push_wr(6'd0, 32'd1, 1, 0);
        push_wr(6'd4, {14'h0, m}, stall_m ? 6 : 1, stall_m ? 8 : 3);
        push_wr(6'd3, {14'h0, n}, 1, 3);
        push_wr(6'd5, {9'h0, 5'd0, c0}, 1, 3);
        push_wr(6'd5, {9'h0, 5'd1, c1}, 1, 3);
        push_wr(6'd8, 32'd6, 1, 3);
        push_wr(6'd9, 32'd3, 1, 3);
        push_wr(6'd2, 32'd1, 1, 3);
        push_ev(K_RD, 32'd0);
        if (timeout) begin
            push_ev(K_ERR, {28'h0, exp_active});
        end else begin
            push_ev(K_DONE, {28'h0, md});
            exp_active = md;
        end
    endtask

    // ------------------------------------------------------------------
    // Status responder: bit 0 rises on poll cycle ready_at; upper bits are
    // junk so that only bit 0 may be interpreted.
    // ------------------------------------------------------------------
    int poll_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mgmt_read) poll_cnt++;
        else poll_cnt = 0;
        mgmt_readdata = 32'hA5A5_A5A4 | ((poll_cnt >= ready_at) ? 32'h1 : 32'h0);
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          last_acc = -1;
    int          hold_cnt = 0;
    int          rd_cycles = 0;
    logic [5:0]  h_addr;
    logic [31:0] h_data;
    logic        rd_prev = 1'b0;
    logic        err_prev = 1'b0;
    logic        done_prev = 1'b0;

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.addr = 0; e.data = 0; e.hold = 0; e.space = 0;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected nothing (t=%0t)",
                     kind, mgmt_address, mgmt_writedata, $time);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        cyc++;
        if (!reset_n) begin
            hold_cnt  = 0;
            last_acc  = -1;
            rd_prev   = 1'b0;
            err_prev  = 1'b0;
            done_prev = 1'b0;
            rd_cycles = 0;
        end else begin
            if (mgmt_write) begin
                if (hold_cnt == 0) begin
                    h_addr = mgmt_address;
                    h_data = mgmt_writedata;
                end
                hold_cnt++;
                if (!mgmt_waitrequest) begin
                    pop_exp(K_WR, e, ok);
                    if (ok) begin
                        chk("wr_addr", mgmt_address, e.addr);
                        chk("wr_data", mgmt_writedata, e.data);
                        chk("wr_hold", hold_cnt, e.hold);
                        chk("wr_stable", {h_addr, h_data}, {mgmt_address, mgmt_writedata});
                        if (e.space > 0) chk("wr_space", cyc - last_acc, e.space);
                    end
                    $display("write addr=%0h data=%08h hold=%0d cycle=%0d", mgmt_address, mgmt_writedata, hold_cnt, cyc);
                    last_acc = cyc;
                    hold_cnt = 0;
                end
            end else begin
                hold_cnt = 0;
            end

            if (mgmt_read) begin
                if (!rd_prev) begin
                    rd_cycles = 0;
                    pop_exp(K_RD, e, ok);
                    if (ok) chk("rd_addr", mgmt_address, e.addr);
                    $display("poll start addr=%0h cycle=%0d", mgmt_address, cyc);
                end
                rd_cycles++;
            end
            rd_prev = mgmt_read;

            if (done) begin
                if (done_prev) begin
                    chk("done_width", 1, 0);
                end else begin
                    pop_exp(K_DONE, e, ok);
                    if (ok) begin
                        chk("done_active_mode", active_mode, e.data[3:0]);
                        chk("done_busy", busy, 0);
                        chk("done_error", error, 0);
                    end
                    $display("done active_mode=%0h poll_cycles=%0d cycle=%0d", active_mode, rd_cycles, cyc);
                end
            end
            done_prev = done;

            if (error && !err_prev) begin
                pop_exp(K_ERR, e, ok);
                if (ok) begin
                    chk("err_active_mode", active_mode, e.data[3:0]);
                    chk("err_busy", busy, 0);
                    chk("err_poll_cycles", rd_cycles, TIMEOUT);
                end
                $display("error active_mode=%0h poll_cycles=%0d cycle=%0d", active_mode, rd_cycles, cyc);
            end
            err_prev = error;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all actions 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_pulse();
        mode_change = 1'b1;
        repeat (3) tick();
        mode_change = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit fin = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            tick();
            if (q.size() == 0 && !busy) fin = 1'b1;
        end
        chk(name, fin, 1);
    endtask

    task automatic wait_write(input string name, input logic [5:0] a);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (mgmt_write && mgmt_address == a) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    task automatic set_inputs(input logic [3:0] md, input logic [17:0] m, input logic [17:0] n,
                              input logic [17:0] c0, input logic [17:0] c1);
        mode = md; m_value = m; n_value = n; c_values = {c1, c0};
    endtask

    // Hand-computed write sequence of the base configuration
    logic [5:0]  base_addr [8] = '{6'd0, 6'd4, 6'd3, 6'd5, 6'd5, 6'd8, 6'd9, 6'd2};
    logic [31:0] base_data [8] = '{32'h1, 32'h20706, 32'h101, 32'h20302, 32'h40505, 32'h6, 32'h3, 32'h1};

    initial begin
        bit seen;

        // Reset
        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata, busy, done, error, active_mode}, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Basic sequence
        set_inputs(4'h3, 18'h20706, 18'h00101, 18'h20302, 18'h00505);
        ready_at = 4;
        for (int i = 0; i < 8; i++) push_wr(base_addr[i], base_data[i], 1, (i == 0) ? 0 : 3);
        push_ev(K_RD, 32'd0);
        push_ev(K_DONE, 32'h3);
        exp_active = 4'h3;
        req_pulse();
        wait_idle("basic_complete", 300);
        repeat (5) tick();

        // Waitrequest stall on the M write
        set_inputs(4'h7, 18'h1_2345, 18'h0_0077, 18'h3_0001, 18'h0_0abc);
        push_seq(4'h7, 18'h1_2345, 18'h0_0077, 18'h3_0001, 18'h0_0abc, 1'b1, 1'b0);
        req_pulse();
        wait_write("stall_find_m", 6'd4);
        mgmt_waitrequest = 1'b1;
        repeat (5) tick();
        mgmt_waitrequest = 1'b0;
        wait_idle("stall_complete", 300);
        repeat (5) tick();

        // Timeout, then a new request clears error
        ready_at = 1000;
        set_inputs(4'h9, 18'h0_0011, 18'h0_0022, 18'h0_0033, 18'h0_0044);
        push_seq(4'h9, 18'h0_0011, 18'h0_0022, 18'h0_0033, 18'h0_0044, 1'b0, 1'b1);
        req_pulse();
        wait_idle("timeout_complete", 300);
        chk("timeout_error_sticky", error, 1);
        chk("timeout_active_mode", active_mode, 4'h7);
        ready_at = 4;
        set_inputs(4'hA, 18'h0_0101, 18'h0_0202, 18'h0_0303, 18'h0_0404);
        push_seq(4'hA, 18'h0_0101, 18'h0_0202, 18'h0_0303, 18'h0_0404, 1'b0, 1'b0);
        req_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) seen = 1'b1;
            else tick();
        end
        chk("restart_busy", seen, 1);
        chk("restart_error_cleared", error, 0);
        wait_idle("restart_complete", 300);
        repeat (5) tick();

        // Two requests during the N write collapse into one queued sequence
        set_inputs(4'h3, 18'h20706, 18'h00101, 18'h20302, 18'h00505);
        push_seq(4'h3, 18'h20706, 18'h00101, 18'h20302, 18'h00505, 1'b0, 1'b0);
        req_pulse();
        wait_write("queue_find_n", 6'd3);
        set_inputs(4'h5, 18'h1_0203, 18'h0_0202, 18'h0_0a0a, 18'h3_ffff);
        push_seq(4'h5, 18'h1_0203, 18'h0_0202, 18'h0_0a0a, 18'h3_ffff, 1'b0, 1'b0);
        mode_change = 1'b1; repeat (2) tick();
        mode_change = 1'b0; repeat (2) tick();
        mode_change = 1'b1; repeat (2) tick();
        mode_change = 1'b0;
        wait_idle("queue_complete", 600);
        repeat (40) tick();

        // Reset during the C write aborts immediately
        set_inputs(4'hC, 18'h0_1111, 18'h0_2222, 18'h0_3333, 18'h0_0444);
        push_seq(4'hC, 18'h0_1111, 18'h0_2222, 18'h0_3333, 18'h0_0444, 1'b0, 1'b0);
        req_pulse();
        wait_write("reset_find_c", 6'd5);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs",
            {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata, busy, done, error, active_mode}, 0);
        q.delete();
        exp_active = 4'h0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (30) tick();
        chk("post_reset_quiet", {busy, mgmt_write, mgmt_read}, 0);

        // Level held high: exactly one sequence
        set_inputs(4'h6, 18'h0_0606, 18'h0_0060, 18'h0_6000, 18'h0_0006);
        push_seq(4'h6, 18'h0_0606, 18'h0_0060, 18'h0_6000, 18'h0_0006, 1'b0, 1'b0);
        mode_change = 1'b1;
        wait_idle("level_complete", 300);
        repeat (40) tick();
        chk("level_no_second", busy, 0);
        mode_change = 1'b0;
        repeat (10) tick();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
